mod_counter: RTL and testbench
==============================

// Module: mod_counter
// PURPOSE
//  Parametrised up/down modulo counter; successor to the fixed 2-bit free-running counter.
//  Adds width/modulus parameters, enable, direction, synchronous load, and three run modes:
//  wrap, saturate and one-shot. Used as the shared tick/event counter in the block-level
//  designs and benches.
// PARAMETERS
//  WIDTH    2            counter width in bits (>=1)
//  MAX_VAL  2**WIDTH-1   terminal value; count range is 0..MAX_VAL; must be < 2**WIDTH
// PORTS
//  clk       in   1       single clock, rising edge
//  rst       in   1       asynchronous, active-high reset
//  en        in   1       count enable
//  up_dn     in   1       1 = count up, 0 = count down
//  load      in   1       synchronous load strobe
//  load_val  in   WIDTH   value captured on load
//  load_mode in   2       mode captured on load (mode_e)
//  cnt       out  WIDTH   current count
//  tc        out  1       cnt equals terminal for current direction (MAX_VAL up, 0 down); combinational from cnt/up_dn
//  wrap      out  1       registered 1-cycle pulse on each wrap
//  done      out  1       one-shot finished (state DONE)
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-high.
//  - Reset: cnt=0, mode_q=MODE_WRAP, state=ST_RUN, wrap=0, done=0.
//  - Priority per cycle: rst > load > en. Load latency is 1 cycle: the value appears on cnt the next cycle.
//  - load: cnt <= min(load_val, MAX_VAL); mode_q <= load_mode; state <= ST_RUN; wrap <= 0.
//  - en=0 and load=0: all state holds; wrap <= 0.
//  - en=1, not at terminal: cnt +/- 1 per up_dn.
//  - en=1, at terminal (up: cnt==MAX_VAL; down: cnt==0):
//      MODE_WRAP    cnt <= 0 (up) or MAX_VAL (down); wrap <= 1 for exactly one cycle.
//      MODE_SAT     cnt holds; wrap stays 0.
//      MODE_ONESHOT cnt holds; state <= ST_DONE.
//  - Reserved mode 2'b11: treat as MODE_WRAP.
//  - FSM, meaningful in ONESHOT only:
//      ST_RUN  -> ST_DONE on terminal with en=1.
//      ST_DONE ignores en; only load or rst leaves it.
//  - done = (state==ST_DONE).
//  - up_dn may change on any cycle; the terminal test always uses the current up_dn.
//  - MAX_VAL=0: the count never moves. Wrap mode pulses wrap every enabled cycle.
//  - rst mid-count or in ST_DONE: immediate asynchronous return to the reset values.
// CONFIGURATION
//  MOD_COUNTER_OVF_STICKY_EN defined:
//   - Adds input ovf_clr (1) and output ovf (1).
//   - ovf is set on any enabled terminal event in any mode, and stays set until ovf_clr or rst.
//   - Same-cycle set and ovf_clr: set wins.
//   - Reset value of ovf is 0.
//  Undefined: ovf_clr and ovf ports are absent; no extra flops.
// STRUCTURE
//  mod_counter_pkg:
//   - typedef enum logic [1:0] mode_e {MODE_WRAP=0, MODE_SAT=1, MODE_ONESHOT=2}
//   - typedef enum logic state_e {ST_RUN, ST_DONE}
//  Single module; no sub-module needed. Terminal-detect logic stays inline.
// TESTING (bench name tb_mod_counter; defaults WIDTH=2, MAX_VAL=3 unless noted)
//  1. rst=1 for 12ns, then en=1, up_dn=1 for 6 clocks
//     -> cnt 0,1,2,3,0,1; wrap high only on the cycle cnt returns 0.
//  2. WIDTH=3, MAX_VAL=5, up_dn=0 from 0
//     -> cnt 0,5,4,3; load_val=7 -> cnt=5 (clamped).
//  3. load_mode=SAT, load_val=2, en=1 up
//     -> cnt 2,3,3,3; wrap never asserts; tc=1 from the cycle cnt=3.
//  4. load_mode=ONESHOT, load_val=1, en=1 up
//     -> cnt 1,2,3; done=1 and holds while en toggles.
//     Then load with load_val=0 -> done=0, counting resumes.
//  5. load=1 and en=1 in the same cycle -> load wins.
//     Assert rst asynchronously mid-count -> cnt=0 before the next edge, done=0.
//  6. With MOD_COUNTER_OVF_STICKY_EN: wrap event -> ovf=1 and it persists.
//     ovf_clr together with a new terminal event -> ovf stays 1.
//     ovf_clr alone -> ovf=0.

Source files
------------

// File: rtl/mod_counter_pkg.sv
// Shared types for the up/down modulo counter: run modes and one-shot FSM states.
package mod_counter_pkg;

    typedef enum logic [1:0] {
        MODE_WRAP    = 2'd0,
        MODE_SAT     = 2'd1,
        MODE_ONESHOT = 2'd2
    } mode_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } state_e;

endpackage

// File: rtl/mod_counter.sv
// Parametrised up/down modulo counter with load, wrap/saturate/one-shot modes.
// Optional sticky overflow flag when MOD_COUNTER_OVF_STICKY_EN is defined.
module mod_counter
    import mod_counter_pkg::*;
#(
    parameter int unsigned WIDTH   = 2,
    parameter int unsigned MAX_VAL = 2**WIDTH-1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [1:0]       load_mode,
`ifdef MOD_COUNTER_OVF_STICKY_EN
    input  logic             ovf_clr,
    output logic             ovf,
`endif
    output logic [WIDTH-1:0] cnt,
    output logic             tc,
    output logic             wrap,
    output logic             done
);

    localparam logic [WIDTH-1:0] MaxCnt = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] r_cnt;
    mode_e            r_mode;
    state_e           r_state;
    logic             r_wrap;

    logic [WIDTH-1:0] w_cnt_nxt;
    mode_e            w_mode_nxt;
    state_e           w_state_nxt;
    logic             w_wrap_nxt;
    logic             w_at_term;
    logic             w_term_evt;

    // Terminal depends on the live direction, not a registered copy.
    assign w_at_term  = up_dn ? (r_cnt == MaxCnt) : (r_cnt == '0);
    assign w_term_evt = !load && en && w_at_term && (r_state == ST_RUN);

    always_comb begin
        w_cnt_nxt   = r_cnt;
        w_mode_nxt  = r_mode;
        w_state_nxt = r_state;
        w_wrap_nxt  = 1'b0;
        if (load) begin
            w_cnt_nxt   = (load_val > MaxCnt) ? MaxCnt : load_val;
            w_state_nxt = ST_RUN;
            if (load_mode == MODE_SAT) begin
                w_mode_nxt = MODE_SAT;
            end else if (load_mode == MODE_ONESHOT) begin
                w_mode_nxt = MODE_ONESHOT;
            end else begin
                w_mode_nxt = MODE_WRAP;
            end
        end else if (en && (r_state == ST_RUN)) begin
            if (!w_at_term) begin
                w_cnt_nxt = up_dn ? (r_cnt + WIDTH'(1)) : (r_cnt - WIDTH'(1));
            end else begin
                case (r_mode)
                    MODE_SAT:     w_cnt_nxt = r_cnt;
                    MODE_ONESHOT: w_state_nxt = ST_DONE;
                    default: begin
                        w_cnt_nxt  = up_dn ? '0 : MaxCnt;
                        w_wrap_nxt = 1'b1;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_mode  <= MODE_WRAP;
            r_state <= ST_RUN;
            r_wrap  <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_mode  <= w_mode_nxt;
            r_state <= w_state_nxt;
            r_wrap  <= w_wrap_nxt;
        end
    end

`ifdef MOD_COUNTER_OVF_STICKY_EN
    logic r_ovf;
    logic w_ovf_nxt;

    // A new terminal event beats a same-cycle clear.
    always_comb begin
        w_ovf_nxt = r_ovf;
        if (w_term_evt) begin
            w_ovf_nxt = 1'b1;
        end else if (ovf_clr) begin
            w_ovf_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else begin
            r_ovf <= w_ovf_nxt;
        end
    end

    assign ovf = r_ovf;
`else
    logic w_unused_term_evt;
    assign w_unused_term_evt = w_term_evt;
`endif

    assign cnt  = r_cnt;
    assign tc   = w_at_term;
    assign wrap = r_wrap;
    assign done = (r_state == ST_DONE);

endmodule

// File: tb/tb_mod_counter.sv
// Directed bench for mod_counter: default 2-bit instance plus a WIDTH=3/MAX_VAL=5 instance.
// Sticky-overflow checks run when MOD_COUNTER_OVF_STICKY_EN is defined.
module tb_mod_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       en_a = 1'b0, up_dn_a = 1'b1, load_a = 1'b0;
    logic [1:0] load_val_a = 2'd0, load_mode_a = 2'd0;
    logic [1:0] cnt_a;
    logic       tc_a, wrap_a, done_a;

    logic       en_b = 1'b0, up_dn_b = 1'b1, load_b = 1'b0;
    logic [2:0] load_val_b = 3'd0;
    logic [1:0] load_mode_b = 2'd0;
    logic [2:0] cnt_b;
    logic       tc_b, wrap_b, done_b;

`ifdef MOD_COUNTER_OVF_STICKY_EN
    logic ovf_clr_a = 1'b0;
    logic ovf_a, ovf_b;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mod_counter u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .en        (en_a),
        .up_dn     (up_dn_a),
        .load      (load_a),
        .load_val  (load_val_a),
        .load_mode (load_mode_a),
`ifdef MOD_COUNTER_OVF_STICKY_EN
        .ovf_clr   (ovf_clr_a),
        .ovf       (ovf_a),
`endif
        .cnt       (cnt_a),
        .tc        (tc_a),
        .wrap      (wrap_a),
        .done      (done_a)
    );

    mod_counter #(
        .WIDTH   (3),
        .MAX_VAL (5)
    ) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .en        (en_b),
        .up_dn     (up_dn_b),
        .load      (load_b),
        .load_val  (load_val_b),
        .load_mode (load_mode_b),
`ifdef MOD_COUNTER_OVF_STICKY_EN
        .ovf_clr   (1'b0),
        .ovf       (ovf_b),
`endif
        .cnt       (cnt_b),
        .tc        (tc_b),
        .wrap      (wrap_b),
        .done      (done_b)
    );

    // Advance one clock; outputs are then sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #12;
        n_tests++;
        if (cnt_a !== 2'd0 || wrap_a !== 1'b0 || done_a !== 1'b0 || tc_a !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_a: cnt=%0d wrap=%0b done=%0b tc=%0b, want 0 0 0 0",
                     cnt_a, wrap_a, done_a, tc_a);
        end
        n_tests++;
        if (cnt_b !== 3'd0 || done_b !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_b: cnt=%0d done=%0b, want 0 0", cnt_b, done_b);
        end
        rst = 1'b0;
    endtask

    task automatic test_wrap_up();
        int exp_cnt[6]  = '{0, 1, 2, 3, 0, 1};
        int exp_wrap[6] = '{0, 0, 0, 0, 1, 0};
        int exp_tc[6]   = '{0, 0, 0, 1, 0, 0};
        en_a    = 1'b1;
        up_dn_a = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) step();
            n_tests++;
            if (cnt_a !== 2'(exp_cnt[i]) || wrap_a !== 1'(exp_wrap[i]) ||
                tc_a !== 1'(exp_tc[i])) begin
                n_fail++;
                $display("FAIL wrap_up[%0d]: cnt=%0d wrap=%0b tc=%0b, want %0d %0d %0d",
                         i, cnt_a, wrap_a, tc_a, exp_cnt[i], exp_wrap[i], exp_tc[i]);
            end
        end
        en_a = 1'b0;
    endtask

    task automatic test_down_clamp();
        int exp_cnt[4]  = '{0, 5, 4, 3};
        int exp_wrap[4] = '{0, 1, 0, 0};
        en_b    = 1'b1;
        up_dn_b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step();
            n_tests++;
            if (cnt_b !== 3'(exp_cnt[i]) || wrap_b !== 1'(exp_wrap[i])) begin
                n_fail++;
                $display("FAIL down_b[%0d]: cnt=%0d wrap=%0b, want %0d %0d",
                         i, cnt_b, wrap_b, exp_cnt[i], exp_wrap[i]);
            end
        end
        en_b       = 1'b0;
        load_b     = 1'b1;
        load_val_b = 3'd7;
        step();
        load_b = 1'b0;
        n_tests++;
        if (cnt_b !== 3'd5) begin
            n_fail++;
            $display("FAIL clamp_b: cnt=%0d, want 5", cnt_b);
        end
    endtask

    task automatic test_saturate();
        int exp_cnt[4] = '{2, 3, 3, 3};
        int exp_tc[4]  = '{0, 1, 1, 1};
        load_a      = 1'b1;
        load_val_a  = 2'd2;
        load_mode_a = 2'd1;
        up_dn_a     = 1'b1;
        step();
        load_a = 1'b0;
        en_a   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step();
            n_tests++;
            if (cnt_a !== 2'(exp_cnt[i]) || wrap_a !== 1'b0 || tc_a !== 1'(exp_tc[i])) begin
                n_fail++;
                $display("FAIL sat[%0d]: cnt=%0d wrap=%0b tc=%0b, want %0d 0 %0d",
                         i, cnt_a, wrap_a, tc_a, exp_cnt[i], exp_tc[i]);
            end
        end
        en_a = 1'b0;
    endtask

    task automatic test_oneshot();
        int exp_cnt[4]  = '{1, 2, 3, 3};
        int exp_done[4] = '{0, 0, 0, 1};
        load_a      = 1'b1;
        load_val_a  = 2'd1;
        load_mode_a = 2'd2;
        step();
        load_a = 1'b0;
        en_a   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step();
            n_tests++;
            if (cnt_a !== 2'(exp_cnt[i]) || done_a !== 1'(exp_done[i])) begin
                n_fail++;
                $display("FAIL oneshot[%0d]: cnt=%0d done=%0b, want %0d %0d",
                         i, cnt_a, done_a, exp_cnt[i], exp_done[i]);
            end
        end
        // DONE ignores en and direction.
        for (int i = 0; i < 4; i++) begin
            en_a    = i[0];
            up_dn_a = (i != 2);
            step();
            n_tests++;
            if (cnt_a !== 2'd3 || done_a !== 1'b1) begin
                n_fail++;
                $display("FAIL oneshot_hold[%0d]: cnt=%0d done=%0b, want 3 1", i, cnt_a, done_a);
            end
        end
        up_dn_a    = 1'b1;
        en_a       = 1'b0;
        load_a     = 1'b1;
        load_val_a = 2'd0;
        step();
        load_a = 1'b0;
        n_tests++;
        if (cnt_a !== 2'd0 || done_a !== 1'b0) begin
            n_fail++;
            $display("FAIL oneshot_reload: cnt=%0d done=%0b, want 0 0", cnt_a, done_a);
        end
        en_a = 1'b1;
        step();
        n_tests++;
        if (cnt_a !== 2'd1 || done_a !== 1'b0) begin
            n_fail++;
            $display("FAIL oneshot_resume: cnt=%0d done=%0b, want 1 0", cnt_a, done_a);
        end
        en_a = 1'b0;
    endtask

    task automatic test_priority_async_rst();
        load_a      = 1'b1;
        en_a        = 1'b1;
        load_val_a  = 2'd3;
        load_mode_a = 2'd0;
        step();
        load_a = 1'b0;
        n_tests++;
        if (cnt_a !== 2'd3) begin
            n_fail++;
            $display("FAIL load_over_en: cnt=%0d, want 3", cnt_a);
        end
        step();
        n_tests++;
        if (cnt_a !== 2'd0 || wrap_a !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_after_load: cnt=%0d wrap=%0b, want 0 1", cnt_a, wrap_a);
        end
        step();
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if (cnt_a !== 2'd0 || wrap_a !== 1'b0 || done_a !== 1'b0) begin
            n_fail++;
            $display("FAIL async_rst_mid: cnt=%0d wrap=%0b done=%0b, want 0 0 0",
                     cnt_a, wrap_a, done_a);
        end
        #2 rst = 1'b0;
        load_a      = 1'b1;
        load_val_a  = 2'd3;
        load_mode_a = 2'd2;
        step();
        load_a = 1'b0;
        step();
        n_tests++;
        if (done_a !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_rst_done: done=%0b, want 1", done_a);
        end
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if (cnt_a !== 2'd0 || done_a !== 1'b0) begin
            n_fail++;
            $display("FAIL async_rst_done: cnt=%0d done=%0b, want 0 0", cnt_a, done_a);
        end
        #2 rst = 1'b0;
        en_a = 1'b0;
        step();
        // Reset restores wrap mode and RUN: counting from 0 must resume.
        en_a = 1'b1;
        step();
        en_a = 1'b0;
        n_tests++;
        if (cnt_a !== 2'd1 || done_a !== 1'b0) begin
            n_fail++;
            $display("FAIL post_rst_count: cnt=%0d done=%0b, want 1 0", cnt_a, done_a);
        end
    endtask

`ifdef MOD_COUNTER_OVF_STICKY_EN
    task automatic test_ovf_sticky();
        rst = 1'b1;
        #2 rst = 1'b0;
        n_tests++;
        if (ovf_a !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_reset: ovf=%0b, want 0", ovf_a);
        end
        en_a    = 1'b1;
        up_dn_a = 1'b1;
        step();
        step();
        step();
        n_tests++;
        if (cnt_a !== 2'd3 || ovf_a !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_pre: cnt=%0d ovf=%0b, want 3 0", cnt_a, ovf_a);
        end
        step();
        en_a = 1'b0;
        step();
        n_tests++;
        if (ovf_a !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_set_hold: ovf=%0b, want 1", ovf_a);
        end
        en_a = 1'b1;
        step();
        step();
        step();
        ovf_clr_a = 1'b1;
        step();
        n_tests++;
        if (ovf_a !== 1'b1 || cnt_a !== 2'd0) begin
            n_fail++;
            $display("FAIL ovf_set_wins: ovf=%0b cnt=%0d, want 1 0", ovf_a, cnt_a);
        end
        en_a = 1'b0;
        step();
        ovf_clr_a = 1'b0;
        n_tests++;
        if (ovf_a !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clr: ovf=%0b, want 0", ovf_a);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_wrap_up();
        test_down_clamp();
        test_saturate();
        test_oneshot();
        test_priority_async_rst();
`ifdef MOD_COUNTER_OVF_STICKY_EN
        test_ovf_sticky();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
